// File: rtl/uart_pkg.sv
// Shared types and constants for the uart_tx arbiter slice.
// Channel indices are always CH_IDX_W wide so every NUM_CH up to MAX_CH uses the same index type.
package uart_pkg;

    localparam int MAX_CH   = 8;
    localparam int CH_IDX_W = 3;

    typedef enum logic [1:0] {
        S_ARB        = 2'd0,
        S_ISSUE      = 2'd1,
        S_WAIT_START = 2'd2,
        S_WAIT_DONE  = 2'd3
    } arb_state_t;

    // Adds a small offset to a channel index and wraps it into 0..numCh-1.
    function automatic logic [CH_IDX_W-1:0] wrapAdd(
        input logic [CH_IDX_W-1:0] base,
        input int                  offset,
        input int                  numCh
    );
        int sum;
        sum = int'(base) + offset;
        if (sum >= numCh) sum = sum - numCh;
        return sum[CH_IDX_W-1:0];
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational rotating-priority picker: the first request at or after i_Ptr wins.
// With the lock enabled only the locked channel may win.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]   i_Req,
    input  logic [CH_IDX_W-1:0] i_Ptr,
    input  logic                i_LockEn,
    input  logic [CH_IDX_W-1:0] i_LockIdx,
    output logic                o_Found,
    output logic [CH_IDX_W-1:0] o_Winner
);

    logic [MAX_CH-1:0]   w_ReqPad;
    logic [CH_IDX_W-1:0] w_Idx;

    // Padding to MAX_CH lets every channel index select a bit without width games.
    always_comb begin
        w_ReqPad = MAX_CH'(i_Req);
        w_Idx    = '0;
        o_Found  = 1'b0;
        o_Winner = '0;
        if (i_LockEn) begin
            o_Found  = w_ReqPad[i_LockIdx];
            o_Winner = i_LockIdx;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                w_Idx = wrapAdd(i_Ptr, k, NUM_CH);
                if (!o_Found && w_ReqPad[w_Idx]) begin
                    o_Found  = 1'b1;
                    o_Winner = w_Idx;
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx between NUM_CH byte requesters,
// with an optional packet lock that holds the grant until the owner's last byte.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic                  i_SysClock,
    input  logic                  i_Reset,
    input  logic [NUM_CH-1:0]     i_ReqValid,
    input  logic [8*NUM_CH-1:0]   i_ReqByte,
    input  logic [NUM_CH-1:0]     i_ReqLast,
    output logic [NUM_CH-1:0]     o_ReqReady,
    output logic [NUM_CH-1:0]     o_Grant,
    output logic                  o_TxValid,
    output logic [7:0]            o_TxByte,
    input  logic                  i_TxDone,
    output logic                  o_Busy
);

    arb_state_t          r_State;
    arb_state_t          w_NextState;
    logic [CH_IDX_W-1:0] r_RrPtr;
    logic [CH_IDX_W-1:0] r_LockIdx;
    logic                r_Locked;
    logic [NUM_CH-1:0]   r_Grant;
    logic                r_TxValid;
    logic [7:0]          r_TxByte;

    logic                w_Found;
    logic [CH_IDX_W-1:0] w_Winner;
    logic                w_Accept;
    logic [NUM_CH-1:0]   w_WinOneHot;
    logic [7:0]          w_WinByte;
    logic                w_WinLast;

    uart_rr_pick #(
        .NUM_CH (NUM_CH)
    ) u_pick (
        .i_Req     (i_ReqValid),
        .i_Ptr     (r_RrPtr),
        .i_LockEn  (r_Locked),
        .i_LockIdx (r_LockIdx),
        .o_Found   (w_Found),
        .o_Winner  (w_Winner)
    );

    always_comb begin
        w_WinOneHot = '0;
        w_WinByte   = '0;
        w_WinLast   = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_Winner == CH_IDX_W'(k)) begin
                w_WinOneHot[k] = 1'b1;
                w_WinByte      = i_ReqByte[8*k +: 8];
                w_WinLast      = i_ReqLast[k];
            end
        end
    end

    // Only S_WAIT_DONE -> S_ARB depends on the done flag rising; a rise seen in S_WAIT_START is ignored.
    always_comb begin
        w_NextState = r_State;
        w_Accept    = 1'b0;
        case (r_State)
            S_ARB: begin
                if (i_TxDone && w_Found) begin
                    w_Accept    = 1'b1;
                    w_NextState = S_ISSUE;
                end
            end
            S_ISSUE:      w_NextState = S_WAIT_START;
            S_WAIT_START: if (!i_TxDone) w_NextState = S_WAIT_DONE;
            S_WAIT_DONE:  if (i_TxDone) w_NextState = S_ARB;
            default:      w_NextState = S_ARB;
        endcase
    end

    always_ff @(posedge i_SysClock) begin
        if (i_Reset) begin
            r_State <= S_ARB;
        end else begin
            r_State <= w_NextState;
        end
    end

    // The pointer advances even on locked grants so arbitration resumes at owner+1 after unlock.
    always_ff @(posedge i_SysClock) begin
        if (i_Reset) begin
            r_RrPtr   <= '0;
            r_Locked  <= 1'b0;
            r_LockIdx <= '0;
            r_Grant   <= '0;
            r_TxValid <= 1'b0;
            r_TxByte  <= 8'h00;
        end else begin
            r_TxValid <= w_Accept;
            if (w_Accept) begin
                r_TxByte  <= w_WinByte;
                r_Grant   <= w_WinOneHot;
                r_Locked  <= !w_WinLast;
                r_LockIdx <= w_Winner;
                r_RrPtr   <= wrapAdd(w_Winner, 1, NUM_CH);
            end else if (r_State == S_WAIT_DONE && i_TxDone && !r_Locked) begin
                r_Grant <= '0;
            end
        end
    end

    assign o_ReqReady = w_Accept ? w_WinOneHot : '0;
    assign o_Grant    = r_Grant;
    assign o_TxValid  = r_TxValid;
    assign o_TxByte   = r_TxByte;
    assign o_Busy     = (r_State != S_ARB);

endmodule
